// File: rtl/mem_access_stage.sv
// MEM stage data-memory access controller: one request per load/store with ack
// handshake, byte-lane steering for stores, and alignment/extension for loads.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  DSize,
  input  logic        loadSign,
  input  logic [0:31] aluResult,
  input  logic [0:31] storeData,
  input  logic [0:31] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [0:31] dmem_addr,
  output logic [0:31] dmem_wdata,
  output logic [0:3]  dmem_be,
  output logic [0:31] dataOut,
  output logic        stall,
  output logic        misalign
);

  // state  | meaning
  // S_IDLE | no access outstanding; a valid access issues a request
  // S_WAIT | request outstanding, waiting for dmem_ack
  // S_DONE | access complete, pipeline released for one cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_req;
  logic        r_we;
  logic [0:31] r_addr;
  logic [0:31] r_wdata;
  logic [0:3]  r_be;
  logic [0:31] r_dout;
  logic [1:0]  r_size;
  logic [0:1]  r_lane;
  logic        r_sign;
  logic        r_load;

  logic        w_access;
  logic        w_misalign;
  logic        w_start;
  logic [0:31] w_wdata;
  logic [0:3]  w_be;
  logic [0:7]  w_byte;
  logic [0:15] w_half;
  logic [0:31] w_load;

  always_comb begin
    w_access   = memRead | memWrite;
    w_misalign = w_access & (((DSize == 2'b01) & aluResult[31]) |
                             (DSize[1] & (aluResult[30:31] != 2'b00)));
    w_start    = (r_state == S_IDLE) & w_access & ~w_misalign;

    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_WAIT;
      S_WAIT:  if (dmem_ack) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Store lanes follow the live address; memory picks the lane with be.
  always_comb begin
    w_wdata = storeData;
    w_be    = 4'b1111;
    case (DSize)
      2'b00: begin
        w_wdata = {4{storeData[24:31]}};
        w_be    = 4'b1000 >> aluResult[30:31];
      end
      2'b01: begin
        w_wdata = {2{storeData[16:31]}};
        w_be    = aluResult[30] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

  // Load alignment uses the attributes captured when the request was issued.
  always_comb begin
    case (r_lane)
      2'b00:   w_byte = dmem_rdata[0:7];
      2'b01:   w_byte = dmem_rdata[8:15];
      2'b10:   w_byte = dmem_rdata[16:23];
      default: w_byte = dmem_rdata[24:31];
    endcase
    w_half = r_lane[0] ? dmem_rdata[16:31] : dmem_rdata[0:15];
    case (r_size)
      2'b00:   w_load = {{24{r_sign & w_byte[0]}}, w_byte};
      2'b01:   w_load = {{16{r_sign & w_half[0]}}, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_dout  <= '0;
      r_size  <= 2'b00;
      r_lane  <= 2'b00;
      r_sign  <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= memWrite;
            r_addr  <= {aluResult[0:29], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_size  <= DSize;
            r_lane  <= aluResult[30:31];
            r_sign  <= loadSign;
            r_load  <= memRead & ~memWrite;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (r_load) r_dout <= w_load;
          end
        end
        default: begin
          r_req <= 1'b0;
          r_we  <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign dataOut    = r_dout;
  assign stall      = w_start | (r_state == S_WAIT);
  assign misalign   = w_misalign;

endmodule
